// File: rtl/timer_multi_if.sv
// Bus bundle for timer_multi: channel config write port, irq acknowledge and the timer outputs.
// With TIMER_PRIO_EN defined the bundle also carries irq_any / irq_id.
interface timer_multi_if #(
    parameter int NCH   = 4,
    parameter int CH_W  = 2,
    parameter int CNT_W = 6
);
    // Handshake: we is a one-cycle valid strobe with no ready; the timer takes a write on
    // every posedge where we=1, so the master holds wch/wbase/wumbral/wmode/wen for that cycle.
    logic                   we;
    logic [CH_W-1:0]        wch;
    logic [2:0]             wbase;
    logic [CNT_W-1:0]       wumbral;
    logic                   wmode;
    logic                   wen;
    logic [NCH-1:0]         ack;
    logic [NCH-1:0]         tick;
    logic [NCH-1:0]         irq;
    logic                   busy;
    logic [NCH-1:0][1:0]    state;
`ifdef TIMER_PRIO_EN
    logic                   irq_any;
    logic [CH_W-1:0]        irq_id;
`endif

    modport master (
        output we, wch, wbase, wumbral, wmode, wen, ack,
`ifdef TIMER_PRIO_EN
        input  irq_any, irq_id,
`endif
        input  tick, irq, busy, state
    );

    modport slave (
        input  we, wch, wbase, wumbral, wmode, wen, ack,
`ifdef TIMER_PRIO_EN
        output irq_any, irq_id,
`endif
        output tick, irq, busy, state
    );
endinterface

// File: rtl/timer_multi.sv
// Multi-channel programmable timer: per-channel prescaler + threshold counter, periodic or one-shot.
// Optional TIMER_PRIO_EN adds irq_any and lowest-index irq_id; state of each channel is exposed on bus.state.
module timer_multi #(
    parameter int NCH      = 4,
    parameter int CH_W     = 2,
    parameter int CNT_W    = 6,
    parameter int BASE_DIV = 20
) (
    input  logic           clk,
    input  logic           reset,
    timer_multi_if.slave   bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t             state_q  [NCH];
    state_t             state_d  [NCH];
    logic [31:0]        presc_q  [NCH];
    logic [31:0]        presc_d  [NCH];
    logic [CNT_W-1:0]   cnt_q    [NCH];
    logic [CNT_W-1:0]   cnt_d    [NCH];
    logic [CNT_W-1:0]   umbral_q [NCH];
    logic [CNT_W-1:0]   umbral_d [NCH];
    logic [2:0]         base_q   [NCH];
    logic [2:0]         base_d   [NCH];
    logic [NCH-1:0]     mode_q, mode_d;
    logic [NCH-1:0]     tick_q, tick_d;
    logic [NCH-1:0]     irq_q, irq_d;
    logic [NCH-1:0]     wr_hit, wrap, expire;
    logic               busy_q, busy_d;
    logic               cfg_ok;

    function automatic logic [31:0] divisor(input logic [2:0] base);
        case (base)
            3'd0:    return 32'(BASE_DIV);
            3'd1:    return 32'(10 * BASE_DIV);
            3'd2:    return 32'(100 * BASE_DIV);
            3'd3:    return 32'(1000 * BASE_DIV);
            3'd4:    return 32'(60000 * BASE_DIV);
            default: return 32'd0;
        endcase
    endfunction

    // A write that lands on the same edge as an expiry restarts the channel and suppresses that expiry.
    always_comb begin
        cfg_ok = bus.wen && (bus.wumbral != '0) && (bus.wbase <= 3'd4);
        for (int i = 0; i < NCH; i++) begin
            wr_hit[i] = bus.we && (bus.wch == CH_W'(i));
            wrap[i]   = (presc_q[i] == divisor(base_q[i]) - 32'd1);
            expire[i] = (state_q[i] == RUN) && wrap[i] &&
                        (cnt_q[i] == umbral_q[i] - CNT_W'(1)) && !wr_hit[i];
        end
    end

    // Next-state logic
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            if (wr_hit[i]) begin
                state_d[i] = cfg_ok ? RUN : IDLE;
            end else begin
                case (state_q[i])
                    RUN:     if (expire[i] && mode_q[i]) state_d[i] = DONE;
                    default: state_d[i] = state_q[i];
                endcase
            end
        end
    end

    // Datapath and output next values
    always_comb begin
        busy_d = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            presc_d[i]  = presc_q[i];
            cnt_d[i]    = cnt_q[i];
            umbral_d[i] = umbral_q[i];
            base_d[i]   = base_q[i];
            mode_d[i]   = mode_q[i];
            tick_d[i]   = expire[i];
            irq_d[i]    = expire[i] | (irq_q[i] & ~bus.ack[i]);
            if (wr_hit[i]) begin
                presc_d[i]  = '0;
                cnt_d[i]    = '0;
                umbral_d[i] = bus.wumbral;
                base_d[i]   = bus.wbase;
                mode_d[i]   = bus.wmode;
            end else if (state_q[i] == RUN) begin
                if (wrap[i]) begin
                    presc_d[i] = '0;
                    cnt_d[i]   = expire[i] ? '0 : cnt_q[i] + CNT_W'(1);
                end else begin
                    presc_d[i] = presc_q[i] + 32'd1;
                end
            end
            if (state_d[i] == RUN) busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i]  <= IDLE;
                presc_q[i]  <= '0;
                cnt_q[i]    <= '0;
                umbral_q[i] <= '0;
                base_q[i]   <= '0;
            end
            mode_q <= '0;
            tick_q <= '0;
            irq_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i]  <= state_d[i];
                presc_q[i]  <= presc_d[i];
                cnt_q[i]    <= cnt_d[i];
                umbral_q[i] <= umbral_d[i];
                base_q[i]   <= base_d[i];
            end
            mode_q <= mode_d;
            tick_q <= tick_d;
            irq_q  <= irq_d;
            busy_q <= busy_d;
        end
    end

    assign bus.tick = tick_q;
    assign bus.irq  = irq_q;
    assign bus.busy = busy_q;

    always_comb begin
        for (int i = 0; i < NCH; i++) bus.state[i] = state_q[i];
    end

`ifdef TIMER_PRIO_EN
    always_comb begin
        bus.irq_any = |irq_q;
        bus.irq_id  = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (irq_q[i]) bus.irq_id = CH_W'(i);
        end
    end
`endif
endmodule

// File: tb/tb_timer_multi.sv
// Self-checking bench for timer_multi: expected tick cycles are queued at config time and
// matched against observed ticks; irq/busy/state are checked at chosen cycles.
module tb_timer_multi;
    localparam int NCH      = 4;
    localparam int CH_W     = 2;
    localparam int CNT_W    = 6;
    localparam int BASE_DIV = 20;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] key;

    timer_multi_if #(.NCH(NCH), .CH_W(CH_W), .CNT_W(CNT_W)) bus ();

    timer_multi #(.NCH(NCH), .CH_W(CH_W), .CNT_W(CNT_W), .BASE_DIV(BASE_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // clock / cycle counter: cyc equals the number of posedges seen
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=0x%0h exp=0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Remove queued ticks still in the future, for one channel or for all.
    task automatic drop(input int ch, input bit all);
        logic [31:0] keep[$];
        keep = {};
        foreach (exp_q[i]) begin
            if (!((all || (exp_q[i][2:0] == 3'(ch))) && (int'(exp_q[i][31:3]) > cyc)))
                keep.push_back(exp_q[i]);
        end
        exp_q = keep;
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Config write; called at a negedge, so the write edge is cyc+1.
    task automatic cfg(input int ch, input int base, input int umb, input bit mode,
                       input bit en, input int nticks, output int wc);
        int div;
        wc = cyc + 1;
        drop(ch, 1'b0);
        case (base)
            0: div = BASE_DIV;
            1: div = BASE_DIV * 10;
            2: div = BASE_DIV * 100;
            3: div = BASE_DIV * 1000;
            4: div = BASE_DIV * 60000;
            default: div = 0;
        endcase
        if (en && umb != 0 && div != 0) begin
            for (int k = 1; k <= nticks; k++)
                exp_q.push_back(32'((wc + k * umb * div) * 8 + ch));
            exp_q.sort();
        end
        bus.we      = 1'b1;
        bus.wch     = CH_W'(ch);
        bus.wbase   = 3'(base);
        bus.wumbral = CNT_W'(umb);
        bus.wmode   = mode;
        bus.wen     = en;
        @(negedge clk);
        bus.we = 1'b0;
    endtask

    task automatic pulse_ack(input logic [NCH-1:0] m);
        bus.ack = m;
        @(negedge clk);
        bus.ack = '0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        drop(0, 1'b1);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // scoreboard: misses first, then match every observed tick against the queue head
    always @(negedge clk) begin
        while (exp_q.size() > 0 && int'(exp_q[0][31:3]) < cyc) begin
            check("tick_miss", 32'hFFFF_FFFF, exp_q[0]);
            void'(exp_q.pop_front());
        end
        for (int c = 0; c < NCH; c++) begin
            if (bus.tick[c] === 1'b1) begin
                key = 32'(cyc * 8 + c);
                if (exp_q.size() > 0) begin
                    check("tick", key, exp_q[0]);
                    if (exp_q[0] == key) void'(exp_q.pop_front());
                end else begin
                    check("tick_extra", key, 32'hFFFF_FFFF);
                end
            end
        end
    end

    initial begin
        int w, w2;
        reset = 1'b1;
        bus.we = 1'b0; bus.wch = '0; bus.wbase = '0; bus.wumbral = '0;
        bus.wmode = 1'b0; bus.wen = 1'b0; bus.ack = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_tick", 32'(bus.tick), 0);
        check("rst_irq", 32'(bus.irq), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_state", 32'(bus.state), 0);

        // periodic ch0, 60-cycle period
        cfg(0, 0, 3, 1'b0, 1'b1, 3, w);
        goto(w + 1);  check("p_busy", 32'(bus.busy), 1);
        goto(w + 59); check("p_irq_pre", 32'(bus.irq[0]), 0);
        goto(w + 60); check("p_irq", 32'(bus.irq[0]), 1);
        goto(w + 150); check("p_busy_mid", 32'(bus.busy), 1);
        goto(w + 185);
        cfg(0, 0, 3, 1'b0, 1'b0, 0, w2);
        goto(w2 + 1); check("p_off_busy", 32'(bus.busy), 0);
        pulse_ack(4'b0001);
        check("p_ack", 32'(bus.irq[0]), 0);

        // one-shot ch1, base 001
        cfg(1, 1, 2, 1'b1, 1'b1, 1, w);
        goto(w + 399); check("os_busy", 32'(bus.busy), 1);
        goto(w + 402); check("os_busy_fall", 32'(bus.busy), 0);
        check("os_state", 32'(bus.state[1]), 2);
        goto(w + 450); check("os_irq", 32'(bus.irq[1]), 1);
`ifdef TIMER_PRIO_EN
        check("os_irq_any", 32'(bus.irq_any), 1);
        check("os_irq_id", 32'(bus.irq_id), 1);
`endif
        pulse_ack(4'b0010);
        check("os_ack", 32'(bus.irq[1]), 0);
        goto(w + 900); check("os_hold", 32'(bus.state[1]), 2);

        // ack on the same edge as the expiry loses to the set
        cfg(0, 0, 1, 1'b0, 1'b1, 1, w);
        goto(w + 19); pulse_ack(4'b0001);
        check("same_edge_irq", 32'(bus.irq[0]), 1);
        goto(w + 24); pulse_ack(4'b0001);
        check("late_ack_irq", 32'(bus.irq[0]), 0);
        goto(w + 30);
        cfg(0, 0, 1, 1'b0, 1'b0, 0, w2);

        // invalid base, then zero threshold: channel stays idle
        cfg(2, int'($urandom_range(7, 5)), int'($urandom_range(63, 1)), 1'b0, 1'b1, 0, w);
        goto(w + 2); check("inv_state", 32'(bus.state[2]), 0);
        check("inv_busy", 32'(bus.busy), 0);
        cfg(2, 0, 0, 1'b0, 1'b1, 0, w);
        goto(w + 10000);
        check("zero_irq", 32'(bus.irq[2]), 0);
        check("zero_busy", 32'(bus.busy), 0);
        check("zero_state", 32'(bus.state[2]), 0);

        // rewrite mid-period discards the old count
        cfg(3, 0, 3, 1'b0, 1'b1, 1, w);
        goto(w + 29);
        cfg(3, 0, 2, 1'b0, 1'b1, 1, w2);
        check("rw_wc", 32'(w2), 32'(w + 30));
        goto(w2 + 41); check("rw_irq", 32'(bus.irq[3]), 1);
        goto(w2 + 45);
        cfg(3, 0, 2, 1'b0, 1'b0, 0, w2);

        // simultaneous expiry on ch0 and ch1
        cfg(0, 0, 2, 1'b0, 1'b1, 1, w);
        goto(w + 19);
        cfg(1, 0, 1, 1'b0, 1'b1, 1, w2);
        goto(w + 41); check("sim_irq", 32'(bus.irq), 32'b1011);
        goto(w + 45);
        cfg(0, 0, 2, 1'b0, 1'b0, 0, w2);
        cfg(1, 0, 1, 1'b0, 1'b0, 0, w2);

        // reset mid-count: no tick, everything cleared, channel idle
        cfg(0, 0, 3, 1'b0, 1'b1, 1, w);
        goto(w + 44); pulse_reset();
        check("mr_irq", 32'(bus.irq), 0);
        check("mr_busy", 32'(bus.busy), 0);
        check("mr_state", 32'(bus.state), 0);
        goto(w + 130);
        check("mr_idle", 32'(bus.state[0]), 0);
        check("mr_irq_late", 32'(bus.irq), 0);

        check("q_left", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/timer_multi.md
Name: timer_multi

Overview:
Multi-channel programmable timer, parametrised successor of the single-channel clock divider. It generates periodic or one-shot tick pulses and sticky interrupt requests per channel. The irq lines feed the CPU interrupt vector logic and are cleared by a per-channel acknowledge. Every channel has its own prescaler, threshold counter and mode; each is configured through a shared write port.

Parameters:
NCH, 4, number of independent timer channels (1..8)
CH_W, 2, width of channel select; NCH <= 2**CH_W
CNT_W, 6, width of threshold (umbral) and event counter
BASE_DIV, 20, clk cycles per base unit for base code 000

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high; clears all state
we  input  1  config write strobe, one cycle
wch  input  CH_W  channel to configure; values >= NCH ignored
wbase  input  3  time base code for written channel
wumbral  input  CNT_W  threshold, in base units
wmode  input  1  0 = periodic, 1 = one-shot
wen  input  1  channel enable
ack  input  NCH  per-channel irq acknowledge
tick  output  NCH  one-cycle pulse per expiry
irq  output  NCH  sticky interrupt request
busy  output  1  OR of all channels in RUN

Behaviour:
- Reset: synchronous, active-high, sampled on the clk posedge, with one clock. All channels go to IDLE. Prescaler, counter, base, umbral and mode are cleared to 0. tick, irq and busy are 0 from the cycle after the reset edge. Reset mid-count aborts with no tick.
- Divisor by base code:
  - 000 = BASE_DIV
  - 001 = 10*BASE_DIV
  - 010 = 100*BASE_DIV
  - 011 = 1000*BASE_DIV
  - 100 = 60000*BASE_DIV
  - 101..111 = invalid
- Divisor arithmetic is 32-bit unsigned and computed combinationally from the stored base.
- Per-channel state machine: IDLE, RUN, DONE.
  - Config write (we=1, wch<NCH): stores base, umbral and mode; clears prescaler and counter.
  - Next state after a write is RUN if wen=1, umbral!=0 and base is valid; otherwise IDLE.
  - A write is legal in any state and restarts the channel. irq is not touched by a write.
- RUN:
  - Prescaler increments each cycle.
  - At prescaler == divisor-1: prescaler <- 0 and counter increments.
  - At counter == umbral-1 with the prescaler wrapping: counter <- 0, tick[i] = 1 for exactly the next cycle, irq[i] <- 1.
  - Periodic: stays in RUN. One-shot: goes to DONE.
- DONE: holds, no ticks, until the next config write or reset.
- Latency: the first tick is high in the cycle after the umbral*divisor-th posedge following the write edge. Periodic ticks repeat every umbral*divisor cycles exactly, with no drift.
- irq: ack[i]=1 clears irq[i] at the next edge. If set and ack occur on the same edge, set wins and irq stays 1. ack on a non-pending channel has no effect.
- Channels are fully independent. Simultaneous expiries on several channels all assert in the same cycle.
- busy is registered: 1 while any channel is in RUN.

Optional Feature:
TIMER_PRIO_EN:
- Defined: adds outputs irq_any (1 bit, OR of irq) and irq_id (CH_W bits). irq_id is the lowest-index pending channel, combinational from irq; it is 0 when none are pending.
- Not defined: these ports and their logic are absent; the remaining behaviour is identical.

Test Plan:
1. BASE_DIV=20, write ch0 base=000, umbral=3, periodic, en=1 -> tick[0] pulses at cycles 60, 120, 180 after the write; irq[0]=1 from cycle 60; busy=1 throughout.
2. ch1 one-shot, base=001, umbral=2 -> single tick[1] at cycle 400, then DONE and busy falls. irq[1] stays 1 until ack[1]; it is 0 the cycle after ack.
3. ch0 periodic umbral=1 base=000, ack[0] asserted on the same edge as the expiry at cycle 20 -> irq[0] remains 1; ack at cycle 25 clears it.
4. Write ch2 base=101 or umbral=0 -> channel IDLE, no tick or irq for 10000 cycles, busy=0.
5. ch0 running umbral=3; reset asserted at cycle 45 for 1 cycle -> no tick at 60; all outputs 0; the channel stays IDLE until rewritten.
6. ch3 rewritten at cycle 30 of a 60-cycle period with umbral=2 -> the old count is discarded and the first tick lands at write+40.
